// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RISC-V pipe: forwarding selects,
// load-use / branch / memory-wait stall and flush control, timeout FSM and perf counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             reg_writeM,
  input  logic             reg_writeW,
  input  logic             loadE,
  input  logic             pc_srcE,
  input  logic             mem_reqM,
  input  logic             mem_readyM,
  output logic [1:0]       forward_aE,
  output logic [1:0]       forward_bE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             bubbleW,
  output logic             mem_err,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_WAIT = 2'b01,
    S_ERR  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              lwstall_s;
  logic              memstall_s;

  // M stage has the younger result, so it wins over W when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic wr_m, input logic [4:0] rd_w,
                                         input logic wr_w);
    logic [1:0] sel;
    if ((rs != 5'd0) && wr_m && (rs == rd_m)) begin
      sel = 2'b10;
    end else if ((rs != 5'd0) && wr_w && (rs == rd_w)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign lwstall_s  = loadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
  assign memstall_s = mem_reqM && !mem_readyM;

  // E-stage forwarding mux selects
  always_comb begin
    forward_aE = 2'b00;
    forward_bE = 2'b00;
    if (reset) begin
      forward_aE = 2'b00;
      forward_bE = 2'b00;
    end else begin
      forward_aE = fwd_sel(rs1E, rdM, reg_writeM, rdW, reg_writeW);
      forward_bE = fwd_sel(rs2E, rdM, reg_writeM, rdW, reg_writeW);
    end
  end

  // Memory-wait FSM next state, wait counter and sticky timeout flag
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    if (reset) begin
      state_d    = S_RUN;
      wait_cnt_d = '0;
      mem_err_d  = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (memstall_s) begin
            state_d    = S_WAIT;
            wait_cnt_d = WC_W'(1);
          end else begin
            state_d = S_RUN;
          end
        end
        S_WAIT: begin
          if (mem_readyM) begin
            state_d    = S_RUN;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
            state_d   = S_ERR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d    = S_ERR;
          mem_err_d  = 1'b1;
        end
      endcase
    end
  end

  // Pipeline stall/flush controls; a frozen E stage ignores branch and load-use
  // until memory releases, so both are re-evaluated afterwards.
  always_comb begin
    stallF  = 1'b0;
    stallD  = 1'b0;
    stallE  = 1'b0;
    stallM  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    bubbleW = 1'b0;
    if (reset) begin
      flushD  = 1'b1;
      flushE  = 1'b1;
      bubbleW = 1'b1;
    end else if ((state_q == S_ERR) || memstall_s) begin
      stallF  = 1'b1;
      stallD  = 1'b1;
      stallE  = 1'b1;
      stallM  = 1'b1;
      bubbleW = 1'b1;
    end else begin
      stallF = lwstall_s;
      stallD = lwstall_s;
      flushE = lwstall_s | pc_srcE;
      flushD = pc_srcE;
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stallF && !(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (flushE && !(&flush_cnt_q)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    wait_cnt_q  <= wait_cnt_d;
    mem_err_q   <= mem_err_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign mem_err   = mem_err_q;
  assign busy      = (state_q != S_RUN);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
